// File: rtl/bin_clock_alarm_if.sv
// Pad-side control inputs and LED-side display outputs of the binary alarm clock.
// Latency: none; plain wires grouped for port hookup.
// Backpressure: none; display outputs are continuously valid.
interface bin_clock_alarm_if;
    logic [1:0] set_mode_i;
    logic [1:0] field_i;
    logic       inc_i;
    logic       dec_i;
    logic       mode24_i;
    logic       alarm_en_i;
    logic       alarm_ack_i;
    logic [4:0] hours_o;
    logic [5:0] minutes_o;
    logic [5:0] seconds_o;
    logic       pm_o;
    logic       tick_o;
    logic       alarm_o;

    modport master (
        output set_mode_i, field_i, inc_i, dec_i, mode24_i, alarm_en_i, alarm_ack_i,
        input  hours_o, minutes_o, seconds_o, pm_o, tick_o, alarm_o
    );

    modport slave (
        input  set_mode_i, field_i, inc_i, dec_i, mode24_i, alarm_en_i, alarm_ack_i,
        output hours_o, minutes_o, seconds_o, pm_o, tick_o, alarm_o
    );
endinterface

// File: rtl/bin_clock_alarm.sv
// Binary time-of-day clock with edge-detected set buttons, 12h/24h display and hour:minute alarm.
// Latency: registered state, outputs valid one clk_i edge after the causing input; display map is combinational.
// Backpressure: none; buttons are sampled every cycle and outputs are always valid.
module bin_clock_alarm #(
    parameter int TICKS_PER_SEC = 100,
    parameter int ALARM_SECS    = 60
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    bin_clock_alarm_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS_PER_SEC - 1);
    localparam logic [7:0]    ALARM_LAST = 8'(ALARM_SECS - 1);

    localparam logic [1:0] MODE_RUN       = 2'b00;
    localparam logic [1:0] MODE_SET_TIME  = 2'b01;
    localparam logic [1:0] MODE_SET_ALARM = 2'b10;

    localparam logic [1:0] FIELD_SEC  = 2'b01;
    localparam logic [1:0] FIELD_MIN  = 2'b10;
    localparam logic [1:0] FIELD_HOUR = 2'b11;

    typedef enum logic {
        ALM_IDLE = 1'b0,
        ALM_RING = 1'b1
    } alm_state_t;

    // One wrap-around step of a field whose legal range is 0..top; no carry out.
    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                              input logic up, input logic dn);
        logic [5:0] r;
        r = v;
        if (up) begin
            r = (v == top) ? 6'd0 : v + 6'd1;
        end else if (dn) begin
            r = (v == 6'd0) ? top : v - 6'd1;
        end
        return r;
    endfunction

    logic [PW-1:0] presc, presc_n;
    logic [4:0]    hour, hour_n;
    logic [5:0]    minute, minute_n;
    logic [5:0]    second, second_n;
    logic [4:0]    alarm_h, alarm_h_n;
    logic [5:0]    alarm_m, alarm_m_n;
    logic [7:0]    alarm_cnt, alarm_cnt_n;
    alm_state_t    alm_state, alm_state_n;
    logic          tick_q;
    logic          inc_q, dec_q;

    logic          running;
    logic          tick_now;
    logic          inc_rise, dec_rise;
    logic          step_up, step_dn;
    logic          sec_wrap, min_wrap;
    logic [5:0]    adv_sec, adv_min;
    logic [4:0]    adv_hour;
    logic          alarm_hit;
    logic          alarm_clear;
    logic [4:0]    hours_disp;

    // Button edges and the running/tick condition for this cycle.
    always_comb begin
        running  = (bus.set_mode_i == MODE_RUN) || (bus.set_mode_i == MODE_SET_ALARM);
        tick_now = running && (presc == PRE_LAST);
        inc_rise = bus.inc_i & ~inc_q;
        dec_rise = bus.dec_i & ~dec_q;
        step_up  = inc_rise & ~dec_rise;
        step_dn  = dec_rise & ~inc_rise;
    end

    // Time of day one second ahead, with seconds/minutes/hours carries.
    always_comb begin
        sec_wrap  = (second == 6'd59);
        min_wrap  = (minute == 6'd59);
        adv_sec   = sec_wrap ? 6'd0 : second + 6'd1;
        adv_min   = minute;
        adv_hour  = hour;
        if (sec_wrap) begin
            adv_min = min_wrap ? 6'd0 : minute + 6'd1;
            if (min_wrap) begin
                adv_hour = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end
        end
        alarm_hit = (adv_sec == 6'd0) && (adv_min == alarm_m) && (adv_hour == alarm_h);
    end

    // Prescaler runs only while time is running; frozen modes park it at zero.
    always_comb begin
        presc_n = '0;
        if (running && !tick_now) begin
            presc_n = presc + PW'(1);
        end
    end

    // Next time registers: tick advance, or single-field edits in set-time mode.
    always_comb begin
        second_n = second;
        minute_n = minute;
        hour_n   = hour;
        if (tick_now) begin
            second_n = adv_sec;
            minute_n = adv_min;
            hour_n   = adv_hour;
        end else if (bus.set_mode_i == MODE_SET_TIME) begin
            case (bus.field_i)
                FIELD_SEC:  second_n = step_field(second, 6'd59, step_up, step_dn);
                FIELD_MIN:  minute_n = step_field(minute, 6'd59, step_up, step_dn);
                FIELD_HOUR: hour_n   = 5'(step_field({1'b0, hour}, 6'd23, step_up, step_dn));
                default:    ;
            endcase
        end
    end

    // Next alarm setpoint; only minutes and hours are editable.
    always_comb begin
        alarm_m_n = alarm_m;
        alarm_h_n = alarm_h;
        if (bus.set_mode_i == MODE_SET_ALARM) begin
            case (bus.field_i)
                FIELD_MIN:  alarm_m_n = step_field(alarm_m, 6'd59, step_up, step_dn);
                FIELD_HOUR: alarm_h_n = 5'(step_field({1'b0, alarm_h}, 6'd23, step_up, step_dn));
                default:    ;
            endcase
        end
    end

    // Alarm next state: disarm/ack beats a trigger, a trigger beats the timeout count.
    always_comb begin
        alarm_clear = ~bus.alarm_en_i | bus.alarm_ack_i;
        alm_state_n = alm_state;
        alarm_cnt_n = alarm_cnt;
        if (alarm_clear) begin
            alm_state_n = ALM_IDLE;
        end else if (tick_now && alarm_hit) begin
            alm_state_n = ALM_RING;
            alarm_cnt_n = 8'd0;
        end else if ((alm_state == ALM_RING) && tick_now) begin
            if (alarm_cnt == ALARM_LAST) begin
                alm_state_n = ALM_IDLE;
            end else begin
                alarm_cnt_n = alarm_cnt + 8'd1;
            end
        end
    end

    // Alarm state register and its timeout counter.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            alm_state <= ALM_IDLE;
            alarm_cnt <= 8'd0;
        end else begin
            alm_state <= alm_state_n;
            alarm_cnt <= alarm_cnt_n;
        end
    end

    // Time, prescaler, setpoint and button history registers; history resets high so a held button is not a press.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            presc   <= '0;
            second  <= 6'd0;
            minute  <= 6'd0;
            hour    <= 5'd0;
            alarm_m <= 6'd0;
            alarm_h <= 5'd0;
            tick_q  <= 1'b0;
            inc_q   <= 1'b1;
            dec_q   <= 1'b1;
        end else begin
            presc   <= presc_n;
            second  <= second_n;
            minute  <= minute_n;
            hour    <= hour_n;
            alarm_m <= alarm_m_n;
            alarm_h <= alarm_h_n;
            tick_q  <= tick_now;
            inc_q   <= bus.inc_i;
            dec_q   <= bus.dec_i;
        end
    end

    // Display hour mapping: 24h passes through, 12h shows 12 for hours 0 and 12.
    always_comb begin
        hours_disp = hour;
        if (!bus.mode24_i) begin
            if (hour == 5'd0) begin
                hours_disp = 5'd12;
            end else if (hour > 5'd12) begin
                hours_disp = hour - 5'd12;
            end
        end
    end

    // Output drive; alarm_o is the registered ringing state.
    always_comb begin
        bus.hours_o   = hours_disp;
        bus.minutes_o = minute;
        bus.seconds_o = second;
        bus.pm_o      = (hour >= 5'd12);
        bus.tick_o    = tick_q;
        bus.alarm_o   = (alm_state == ALM_RING);
    end

endmodule

// File: doc/bin_clock_alarm.md
Name: bin_clock_alarm

Overview:
- Parametrised successor to the binary time-of-day counter.
- Keeps hours in an internal 0-23 register and presents it in 12h or 24h form, selectable at run time.
- Set-mode buttons are edge-detected, so each press steps a field exactly once.
- Adds an hour:minute alarm with acknowledge and auto-timeout, plus a 1 Hz tick output. Sits between the pad inputs and the binary LED output drivers.

Parameters:
- TICKS_PER_SEC, 100, clk_i cycles per second (>=2); prescaler width = $clog2(TICKS_PER_SEC).
- ALARM_SECS, 60, seconds alarm_o stays high before it self-clears (1..255).

Ports:
- clk_i  in  1  system clock.
- reset_ni  in  1  asynchronous active-low reset.
- set_mode_i  in  2  00 run, 01 set time, 10 set alarm, 11 hold.
- field_i  in  2  00 none, 01 seconds, 10 minutes, 11 hours.
- inc_i  in  1  increment button (level; rising edge acts).
- dec_i  in  1  decrement button (level; rising edge acts).
- mode24_i  in  1  1 = 24h display, 0 = 12h display.
- alarm_en_i  in  1  alarm arm.
- alarm_ack_i  in  1  alarm acknowledge (level).
- hours_o  out  5  displayed hours: 0-23 (24h) or 1-12 (12h).
- minutes_o  out  6  0-59.
- seconds_o  out  6  0-59.
- pm_o  out  1  1 when internal hour >= 12, in either display mode.
- tick_o  out  1  one-cycle pulse on each running-second advance.
- alarm_o  out  1  alarm active.

Behaviour:
- Reset (async, reset_ni=0):
  - prescaler=0; hour/min/sec=0; alarm_h=0, alarm_m=0; alarm_o=0; tick_o=0; alarm timeout counter=0.
  - inc/dec edge-detect history regs reset to 1, so a button held through reset does not step.
  - Outputs at reset: hours_o = 0 (24h) or 12 (12h); pm_o=0.
- Prescaler:
  - Runs in modes 00 and 10, counting 0..TICKS_PER_SEC-1.
  - The edge where it equals TICKS_PER_SEC-1 is a tick: prescaler <= 0, time advances, tick_o <= 1 for exactly one cycle.
  - Modes 01 and 11: prescaler forced to 0, no ticks, time frozen. The first second after returning to run is therefore full length.
- Time advance on tick:
  - sec+1; 59 -> 0 carries to min.
  - min 59 -> 0 carries to hour.
  - hour 23 -> 0.
- Display mapping (combinational from registers):
  - 24h: hours_o = hour.
  - 12h: hours_o = 12 if hour mod 12 = 0, else hour mod 12.
- Edge detect: inc_rise = inc_i & ~inc_q; dec_rise likewise.
  - inc_rise and dec_rise in the same cycle: no change.
  - field_i=00: no change.
- Set time (01):
  - One rising edge steps the selected time field by ±1 modulo its range (60/60/24).
  - Wraps do NOT carry into other fields: dec at 0 gives 59 or 23; inc at 59 or 23 gives 0.
- Set alarm (10):
  - Steps alarm_m (field 10) or alarm_h (field 11) with the same wrap rules.
  - field 01 is ignored.
  - Time keeps running in this mode.
- Hold (11): buttons ignored.
- Alarm trigger:
  - On a tick edge whose next time is alarm_h:alarm_m:00 with alarm_en_i=1, alarm_o <= 1 and the timeout counter <= 0.
  - Setting the time to a matching value in mode 01 never triggers.
- Alarm clear:
  - Priority: alarm_en_i=0 or alarm_ack_i=1 clears alarm_o the next edge, and also suppresses a trigger in the same cycle.
  - Otherwise, while alarm_o=1, each tick increments the counter. On the tick where counter = ALARM_SECS-1, alarm_o <= 0.
  - A retrigger on the same cycle as the timeout tick is impossible (alarm period > 60 s); no special handling needed.
- Reset mid-operation: all state returns to reset values immediately (async). Outputs are valid from the first clock after deassertion.

Test Plan:
- TICKS_PER_SEC=4, reset then mode 00 for 12 cycles -> tick_o pulses at cycles 4, 8, 12; seconds_o = 1, 2, 3.
- Preload 23:59:59 via set mode, run one tick -> 00:00:00; mode24_i=0 shows hours_o=12, pm_o=0. At hour 13: hours_o=1, pm_o=1.
- Set mode, field=10, minutes=0, one dec pulse -> minutes_o=59 with hours unchanged. inc held high 10 cycles -> exactly one step. inc and dec rising together -> no change.
- Alarm 07:30 with alarm_en_i=1, time 07:29:59, one tick -> alarm_o=1 on the same edge as 07:30:00. With ALARM_SECS=3, alarm_o falls on the 3rd following tick.
- alarm_o=1, pulse alarm_ack_i for 1 cycle -> alarm_o=0 next edge. Repeat with alarm_en_i dropped -> same result.
- Assert reset_ni=0 mid-second in set-alarm mode with inc_i high -> outputs 0 (hours_o=12 in 12h) asynchronously. Release with inc_i still high -> no step.
